spi_target: RTL



---
 rtl/spi_target_if.sv | 27 ++
 rtl/spi_target.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_target_if.sv
// Bundles the SPI target pins and the CPU-side register bus of spi_target.
// The target pins keep their board-level names.
interface spi_target_if;
    logic       TGT_SCK;
    logic       TGT_SS;
    logic       TGT_MOSI;
    logic       TGT_MISO;
    logic       TGT_MISO_EN;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       active;

    modport slave (
        input  TGT_SCK, TGT_SS, TGT_MOSI, tx_data, tx_load, rx_ack,
        output TGT_MISO, TGT_MISO_EN, tx_ready, rx_data, rx_valid, rx_overrun, active
    );

    modport master (
        output TGT_SCK, TGT_SS, TGT_MOSI, tx_data, tx_load, rx_ack,
        input  TGT_MISO, TGT_MISO_EN, tx_ready, rx_data, rx_valid, rx_overrun, active
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target engine: oversamples SCK/SS/MOSI in the CLK1 domain,
// assembles received bytes and shifts out bytes queued through a one-deep TX buffer.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         CLK1,
    input  logic         RESET_N,
    spi_target_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sck_s_q;
    logic [SYNC_STAGES-1:0] ss_s_q;
    logic [SYNC_STAGES-1:0] mosi_s_q;
    logic                   sck_dly_q;
    logic                   ss_dly_q;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BYTE_W-1:0]   rx_shift_q;
    logic [BYTE_W-1:0]   tx_shift_q;
    logic [BYTE_W-1:0]   tx_buf_q;
    logic                tx_ready_q;
    logic [BYTE_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                rx_overrun_q;
    logic                miso_q;
    logic                miso_en_q;
    logic                active_q;

    logic              sck_c, ss_c, mosi_c;
    logic              sck_rise_c, sck_fall_c, ss_fall_c, ss_rise_c;
    logic [BYTE_W-1:0] load_byte_c;
    logic [BYTE_W-1:0] rx_byte_c;

    // Synchronizers plus one extra stage for edge detection; SS idles high.
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_s_q   <= '0;
            ss_s_q    <= '1;
            mosi_s_q  <= '0;
            sck_dly_q <= 1'b0;
            ss_dly_q  <= 1'b1;
        end else begin
            sck_s_q   <= {sck_s_q[SYNC_STAGES-2:0],  bus.TGT_SCK};
            ss_s_q    <= {ss_s_q[SYNC_STAGES-2:0],   bus.TGT_SS};
            mosi_s_q  <= {mosi_s_q[SYNC_STAGES-2:0], bus.TGT_MOSI};
            sck_dly_q <= sck_s_q[SYNC_STAGES-1];
            ss_dly_q  <= ss_s_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        sck_c       = sck_s_q[SYNC_STAGES-1];
        ss_c        = ss_s_q[SYNC_STAGES-1];
        mosi_c      = mosi_s_q[SYNC_STAGES-1];
        sck_rise_c  = sck_c & ~sck_dly_q;
        sck_fall_c  = ~sck_c & sck_dly_q;
        ss_fall_c   = ~ss_c & ss_dly_q;
        ss_rise_c   = ss_c & ~ss_dly_q;
        load_byte_c = tx_ready_q ? 8'hFF : tx_buf_q;
        rx_byte_c   = {rx_shift_q[BYTE_W-2:0], mosi_c};
    end

    // Transfer FSM; the select-time load happens on the IDLE->SHIFT transition
    // so MISO moves on the same edge the synchronized SS fall takes effect.
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= 8'hFF;
            tx_buf_q     <= '0;
            tx_ready_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            miso_q       <= 1'b1;
            miso_en_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            active_q  <= ~ss_c;
            miso_en_q <= ~ss_c;

            if (bus.tx_load && tx_ready_q) begin
                tx_buf_q   <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end

            if (bus.rx_ack) begin
                rx_valid_q   <= 1'b0;
                rx_overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (ss_fall_c) begin
                        state_q    <= ST_SHIFT;
                        tx_shift_q <= load_byte_c;
                        miso_q     <= load_byte_c[BYTE_W-1];
                        if (!tx_ready_q) tx_ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise_c) begin
                        // Abort: partial RX byte and loaded TX byte are dropped.
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        tx_shift_q <= 8'hFF;
                        miso_q     <= 1'b1;
                    end else if (sck_rise_c) begin
                        rx_shift_q <= rx_byte_c;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                            rx_data_q    <= rx_byte_c;
                            rx_valid_q   <= 1'b1;
                            rx_overrun_q <= bus.rx_ack ? 1'b0 : (rx_overrun_q | rx_valid_q);
                        end
                    end else if (sck_fall_c) begin
                        if (cnt_q != '0) begin
                            tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b1};
                            miso_q     <= tx_shift_q[BYTE_W-2];
                        end else begin
                            tx_shift_q <= load_byte_c;
                            miso_q     <= load_byte_c[BYTE_W-1];
                            if (!tx_ready_q) tx_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.TGT_MISO    = miso_q;
    assign bus.TGT_MISO_EN = miso_en_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.active      = active_q;
endmodule
